// File: rtl/pia_tx_pkg.sv
// Shared types and constants for the Apple-1 display transmitter.
// Holds the handshake state encoding and the character width.
package pia_tx_pkg;

    localparam int CHAR_W = 7;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ASSERT,
        RELEASE
    } tx_state_e;

endpackage

// File: rtl/pia_char_fifo.sv
// Small synchronous character FIFO feeding the display handshake.
// Pushes while full and pops while empty are ignored; clr empties it.
module pia_char_fifo
    import pia_tx_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = CHAR_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           din,
    output logic [W-1:0]           dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign level   = cnt_q;
    assign dout    = mem_q[rptr_q];
    assign push_ok = push & ~full & ~clr;
    assign pop_ok  = pop & ~empty & ~clr;

    // Pointer and occupancy next-state; pointers wrap since DEPTH is 2^n.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (clr) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end else begin
            if (push_ok) wptr_d = wptr_q + 1'b1;
            if (pop_ok)  rptr_d = rptr_q + 1'b1;
            unique case ({push_ok, pop_ok})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Storage array; contents need no reset since occupancy gates reads.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wptr_q] <= din;
    end

endmodule

// File: rtl/pia_display_tx.sv
// Apple-1 display transmitter: buffers CPU characters and drives rd/da
// through a four-phase handshake against the terminal's rda_n acknowledge.
module pia_display_tx
    import pia_tx_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int SETUP_CYCLES = 2,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                          clk,
    input  logic                          mr_n,
    input  logic                          wr_en,
    input  logic [CHAR_W-1:0]             wr_data,
    input  logic                          flush,
    input  logic                          rda_n,
    output logic                          da,
    output logic [CHAR_W-1:0]             rd,
    output logic                          busy,
    output logic                          full,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   level
);

    localparam int CW = $clog2(SETUP_CYCLES) + 1;
    localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYCLES - 1);

    tx_state_e              state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [CHAR_W-1:0]      rd_q, rd_d;
    logic                   da_q, da_d;
    logic                   ovf_q, ovf_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   rda_s;
    logic                   pop;
    logic                   empty;
    logic [CHAR_W-1:0]      head;

    assign rda_s    = sync_q[SYNC_STAGES-1];
    assign sync_d   = {sync_q[SYNC_STAGES-2:0], rda_n};
    assign da       = da_q;
    assign rd       = rd_q;
    assign overflow = ovf_q;
    assign busy     = ~empty | (state_q != IDLE);

    pia_char_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (CHAR_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (mr_n),
        .clr   (flush),
        .push  (wr_en & ~flush),
        .pop   (pop),
        .din   (wr_data),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    // Handshake sequencing: load, settle rd, raise da, wait ack low then high.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        pop     = 1'b0;
        ovf_d   = flush ? 1'b0 : (ovf_q | (wr_en & full));
        unique case (state_q)
            IDLE: begin
                if (!flush && !empty) begin
                    pop     = 1'b1;
                    rd_d    = head;
                    cnt_d   = '0;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (cnt_q >= SETUP_LAST) begin
                    if (rda_s) state_d = ASSERT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ASSERT: begin
                if (flush || !rda_s) state_d = RELEASE;
            end
            RELEASE: begin
                if (rda_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        da_d = (state_d == ASSERT);
    end

    // State, data, strobe and ack synchroniser registers.
    always_ff @(posedge clk or negedge mr_n) begin
        if (!mr_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rd_q    <= '0;
            da_q    <= 1'b0;
            ovf_q   <= 1'b0;
            sync_q  <= '1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            da_q    <= da_d;
            ovf_q   <= ovf_d;
            sync_q  <= sync_d;
        end
    end

endmodule

// File: tb/tb_pia_display_tx.sv
// Directed self-checking bench for the display transmitter.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_pia_display_tx;
    import pia_tx_pkg::*;

    logic              clk;
    logic              mr_n;
    logic              wr_en;
    logic [CHAR_W-1:0] wr_data;
    logic              flush;
    logic              rda_n;
    logic              da;
    logic [CHAR_W-1:0] rd;
    logic              busy;
    logic              full;
    logic              overflow;
    logic [2:0]        level;

    int tests;
    int fails;
    int bad;
    logic [6:0] burst [4];

    pia_display_tx #(
        .FIFO_DEPTH   (4),
        .SETUP_CYCLES (2),
        .SYNC_STAGES  (2)
    ) dut (
        .clk      (clk),
        .mr_n     (mr_n),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .flush    (flush),
        .rda_n    (rda_n),
        .da       (da),
        .rd       (rd),
        .busy     (busy),
        .full     (full),
        .overflow (overflow),
        .level    (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_da(input logic lvl, input int lim, input string tag);
        int k;
        k = 0;
        while (da !== lvl && k < lim) begin
            tick(1);
            k++;
        end
        chk(tag, 32'(da), 32'(lvl));
    endtask

    initial begin
        tests    = 0;
        fails    = 0;
        burst[0] = 7'h48;
        burst[1] = 7'h49;
        burst[2] = 7'h0D;
        burst[3] = 7'h0A;
        mr_n     = 1'b0;
        wr_en    = 1'b0;
        wr_data  = '0;
        flush    = 1'b0;
        rda_n    = 1'b1;

        // reset state
        #12;
        chk("rst_da", 32'(da), 0);
        chk("rst_rd", 32'(rd), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_full", 32'(full), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_level", 32'(level), 0);
        #10 mr_n = 1'b1;
        tick(2);

        // single character, edge N = write accepted
        wr_en   = 1'b1;
        wr_data = 7'h41;
        tick(1);
        wr_en = 1'b0;
        chk("single_lvl_N", 32'(level), 1);
        chk("single_busy_N", 32'(busy), 1);
        tick(1);
        chk("single_rd_N1", 32'(rd), 32'h41);
        chk("single_lvl_N1", 32'(level), 0);
        chk("single_da_N1", 32'(da), 0);
        tick(1);
        chk("single_da_N2", 32'(da), 0);
        tick(1);
        chk("single_da_N3", 32'(da), 1);
        chk("single_busy_N3", 32'(busy), 1);
        rda_n = 1'b0;
        tick(2);
        chk("single_da_ack2", 32'(da), 1);
        tick(1);
        chk("single_da_ack3", 32'(da), 0);
        rda_n = 1'b1;
        tick(2);
        chk("single_busy_rel2", 32'(busy), 1);
        tick(1);
        chk("single_busy_idle", 32'(busy), 0);

        // burst of four with terminal acking after 20 cycles
        wr_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wr_data = burst[i];
            tick(1);
        end
        wr_en = 1'b0;
        for (int c = 0; c < 4; c++) begin
            wait_da(1'b1, 100, "burst_da_rise");
            chk("burst_rd", 32'(rd), 32'(burst[c]));
            bad = 0;
            repeat (20) begin
                if (da && rd !== burst[c]) bad++;
                tick(1);
            end
            chk("burst_rd_stable", 32'(bad), 0);
            rda_n = 1'b0;
            wait_da(1'b0, 5, "burst_da_fall");
            rda_n = 1'b1;
        end
        tick(6);
        chk("burst_ovf", 32'(overflow), 0);
        chk("burst_busy_end", 32'(busy), 0);
        chk("burst_level_end", 32'(level), 0);

        // stuck-low ack holds SETUP
        rda_n = 1'b0;
        tick(3);
        wr_en   = 1'b1;
        wr_data = 7'h55;
        tick(1);
        wr_en = 1'b0;
        tick(6);
        chk("stuck_da", 32'(da), 0);
        chk("stuck_busy", 32'(busy), 1);
        chk("stuck_rd", 32'(rd), 32'h55);
        rda_n = 1'b1;
        tick(2);
        chk("stuck_da_rel2", 32'(da), 0);
        tick(1);
        chk("stuck_da_rel3", 32'(da), 1);
        rda_n = 1'b0;
        tick(3);
        chk("stuck_da_ack", 32'(da), 0);
        rda_n = 1'b1;
        tick(3);
        chk("stuck_idle", 32'(busy), 0);

        // overflow with ack stuck high
        wr_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wr_data = 7'(8'h30 + i);
            tick(1);
        end
        chk("ovf_full_4", 32'(full), 0);
        wr_data = 7'h34;
        tick(1);
        chk("ovf_full_5", 32'(full), 1);
        chk("ovf_flag_5", 32'(overflow), 0);
        chk("ovf_level_5", 32'(level), 4);
        wr_data = 7'h35;
        tick(1);
        wr_en = 1'b0;
        chk("ovf_flag_6", 32'(overflow), 1);
        chk("ovf_level_6", 32'(level), 4);
        chk("ovf_rd", 32'(rd), 32'h30);

        // flush while da is high
        chk("flush_da_pre", 32'(da), 1);
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        chk("flush_da", 32'(da), 0);
        chk("flush_level", 32'(level), 0);
        chk("flush_ovf", 32'(overflow), 0);
        chk("flush_full", 32'(full), 0);
        chk("flush_busy_rel", 32'(busy), 1);
        tick(1);
        chk("flush_busy_idle", 32'(busy), 0);
        tick(5);
        chk("flush_no_da", 32'(da), 0);

        // async reset during RELEASE
        wr_en   = 1'b1;
        wr_data = 7'h52;
        tick(1);
        wr_data = 7'h53;
        tick(1);
        wr_en = 1'b0;
        wait_da(1'b1, 20, "rst_seq_da_rise");
        rda_n = 1'b0;
        tick(3);
        chk("rst_seq_release_da", 32'(da), 0);
        chk("rst_seq_release_lvl", 32'(level), 1);
        #2 mr_n = 1'b0;
        #1;
        chk("arst_da", 32'(da), 0);
        chk("arst_rd", 32'(rd), 0);
        chk("arst_level", 32'(level), 0);
        chk("arst_busy", 32'(busy), 0);
        #4 mr_n = 1'b1;
        rda_n = 1'b1;
        tick(10);
        chk("arst_no_da", 32'(da), 0);
        chk("arst_no_busy", 32'(busy), 0);
        wr_en   = 1'b1;
        wr_data = 7'h21;
        tick(1);
        wr_en = 1'b0;
        tick(3);
        chk("arst_new_da", 32'(da), 1);
        chk("arst_new_rd", 32'(rd), 32'h21);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
